// File: rtl/inst_rom.sv
// inst_rom: instruction memory with a combinational fetch port and a
// byte-stream image loader (little-endian byte assembly into 32-bit words).
// Optional build macro INST_ROM_MISALIGN_EN: when defined, fetches with
// rom_addr[1:0] != 0 return NOP and raise misalign.
module inst_rom #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rom_ce,
    input  logic [31:0]           rom_addr,
    output logic [31:0]           rom_inst,
    input  logic                  load_start,
    input  logic [ADDR_WIDTH:0]   load_words,
    input  logic                  load_valid,
    input  logic [7:0]            load_byte,
    output logic                  load_ready,
    output logic                  load_busy,
    output logic                  load_done,
    output logic                  misalign
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [31:0]           NOP      = 32'h0000_0013;
    localparam logic [ADDR_WIDTH:0]   WORD_ONE = 1;
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = 1;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } state_t;

    state_t                state_reg, state_next;
    logic [ADDR_WIDTH-1:0] wptr_reg, wptr_next;
    logic [1:0]            byte_cnt_reg, byte_cnt_next;
    logic [ADDR_WIDTH:0]   word_cnt_reg, word_cnt_next;
    logic [ADDR_WIDTH:0]   words_reg, words_next;

    logic                  accept;
    logic                  wr_en;
    logic [31:0]           wr_data;
    logic [31:0]           rd_word;
    logic                  mis_hit;
    logic                  unused_addr;

    logic [31:0]           mem [DEPTH];

    // Upper address bits are intentionally ignored so the fetch index wraps.
    assign unused_addr = ^{rom_addr[31:ADDR_WIDTH+2], rom_addr[1:0]};

    assign accept = (state_reg == LOAD) && load_valid;
    // A reset at the 4th-byte edge aborts the load, so that word is not written.
    assign wr_en  = accept && (byte_cnt_reg == 2'd3) && rst;

    // Lanes 0..2 are held in registers across valid gaps; lane 3 comes
    // straight from the 4th byte so the word is written on that same edge.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_lane
            logic [7:0] lane_reg;
            // Capture the byte destined for this lane.
            always_ff @(posedge clk) begin
                if (accept && (byte_cnt_reg == 2'(gi))) begin
                    lane_reg <= load_byte;
                end
            end
            assign wr_data[8*gi +: 8] = lane_reg;
        end
    endgenerate
    assign wr_data[31:24] = load_byte;

    // Image write port; kept outside reset so contents survive it.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wptr_reg] <= wr_data;
        end
    end

    // Asynchronous read: a word written this cycle shows its old value until the edge.
    assign rd_word = mem[rom_addr[ADDR_WIDTH+1:2]];

`ifdef INST_ROM_MISALIGN_EN
    assign mis_hit = rst && rom_ce && (rom_addr[1:0] != 2'b00);
`else
    assign mis_hit = 1'b0;
`endif
    assign misalign = mis_hit;

    // Fetch mux: off/reset gives zero, loading or misaligned gives NOP.
    always_comb begin
        rom_inst = 32'h0000_0000;
        if (rst && rom_ce) begin
            if (load_busy || mis_hit) begin
                rom_inst = NOP;
            end else begin
                rom_inst = rd_word;
            end
        end
    end

    assign load_ready = (state_reg == LOAD);
    assign load_busy  = (state_reg != IDLE);
    assign load_done  = (state_reg == DONE);

    // Loader next-state and counter logic.
    always_comb begin
        state_next    = state_reg;
        wptr_next     = wptr_reg;
        byte_cnt_next = byte_cnt_reg;
        word_cnt_next = word_cnt_reg;
        words_next    = words_reg;
        case (state_reg)
            IDLE: begin
                if (load_start) begin
                    words_next    = load_words;
                    wptr_next     = '0;
                    byte_cnt_next = '0;
                    word_cnt_next = '0;
                    state_next    = (load_words == '0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                if (load_valid) begin
                    byte_cnt_next = byte_cnt_reg + 2'd1;
                    if (byte_cnt_reg == 2'd3) begin
                        wptr_next     = wptr_reg + PTR_ONE;
                        word_cnt_next = word_cnt_reg + WORD_ONE;
                        if (word_cnt_next == words_reg) begin
                            state_next = DONE;
                        end
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Loader state register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg    <= IDLE;
            wptr_reg     <= '0;
            byte_cnt_reg <= '0;
            word_cnt_reg <= '0;
            words_reg    <= '0;
        end else begin
            state_reg    <= state_next;
            wptr_reg     <= wptr_next;
            byte_cnt_reg <= byte_cnt_next;
            word_cnt_reg <= word_cnt_next;
            words_reg    <= words_next;
        end
    end

endmodule

// File: tb/tb_inst_rom.sv
// tb_inst_rom: scoreboard bench for inst_rom (ADDR_WIDTH=2 so wrap is reachable).
// The driver predicts each cycle's outputs from an image-level model and queues
// them; the monitor pops and compares on every falling edge.
module tb_inst_rom;
    localparam int AW    = 2;
    localparam int DEPTH = 1 << AW;
    localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef INST_ROM_MISALIGN_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        rom_ce;
    logic [31:0] rom_addr;
    logic [31:0] rom_inst;
    logic        load_start;
    logic [AW:0] load_words;
    logic        load_valid;
    logic [7:0]  load_byte;
    logic        load_ready;
    logic        load_busy;
    logic        load_done;
    logic        misalign;

    inst_rom #(.ADDR_WIDTH(AW)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .rom_ce     (rom_ce),
        .rom_addr   (rom_addr),
        .rom_inst   (rom_inst),
        .load_start (load_start),
        .load_words (load_words),
        .load_valid (load_valid),
        .load_byte  (load_byte),
        .load_ready (load_ready),
        .load_busy  (load_busy),
        .load_done  (load_done),
        .misalign   (misalign)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        bit          chk_inst;
        bit          mis;
        bit          chk_ctrl;
        bit          ready;
        bit          busy;
        bit          done;
        string       tag;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    bit          chk_en = 1'b0;
    int          checks = 0;
    int          failures = 0;
    logic [31:0] ref_mem [DEPTH];
    bit          known   [DEPTH];

    // Expected fetch response from the memory image and the block's mode.
    function automatic exp_t predict_fetch(input bit r, input bit ce, input logic [31:0] addr,
                                           input bit busy, input string tag);
        exp_t e;
        int   idx;
        bit   odd;
        idx        = int'((addr / 4) % DEPTH);
        odd        = (addr % 4) != 0;
        e.tag      = tag;
        e.chk_inst = 1'b1;
        e.chk_ctrl = 1'b0;
        e.ready    = 1'b0;
        e.busy     = 1'b0;
        e.done     = 1'b0;
        e.mis      = MIS_EN && r && ce && odd;
        if (!r || !ce) begin
            e.inst = 32'h0;
        end else if (busy || e.mis) begin
            e.inst = NOP;
        end else begin
            e.inst     = ref_mem[idx];
            e.chk_inst = known[idx];
        end
        return e;
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = $urandom;
        if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
        return a;
    endfunction

    // Drive one clock's worth of inputs and queue what the outputs must be.
    task automatic cycle(input bit r, input bit ce, input logic [31:0] addr, input bit start,
                         input int nw, input bit v, input logic [7:0] b, input exp_t e);
        rst        = r;
        rom_ce     = ce;
        rom_addr   = addr;
        load_start = start;
        load_words = nw[AW:0];
        load_valid = v;
        load_byte  = b;
        exp_q.push_back(e);
        chk_en     = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_fetch(input bit ce, input logic [31:0] addr, input string tag);
        exp_t e;
        e = predict_fetch(1'b1, ce, addr, 1'b0, tag);
        e.chk_ctrl = 1'b1;
        cycle(1'b1, ce, addr, 1'b0, 0, 1'b0, 8'h00, e);
    endtask

    // Load an image; gap 0=none, 1=alternate, 2=random; abort_at = accepted-byte count
    // at which reset is asserted (-1 for none). Stray load_start pulses are sprinkled in.
    task automatic run_load(input int nw, input logic [7:0] img[$], input int gap,
                            input int abort_at, input string tag);
        exp_t        e;
        logic [31:0] a;
        bit          ce;
        bit          v;
        bit          tog;
        int          acc;
        int          w;
        acc = 0;
        tog = 1'b0;
        a  = rand_addr();
        ce = 1'($urandom_range(0, 1));
        e  = predict_fetch(1'b1, ce, a, 1'b0, {tag, "/start"});
        e.chk_ctrl = 1'b1;
        cycle(1'b1, ce, a, 1'b1, nw, 1'b0, 8'h00, e);
        while (acc < 4 * nw) begin
            a  = rand_addr();
            ce = 1'($urandom_range(0, 1));
            tog = ~tog;
            case (gap)
                0:       v = 1'b1;
                1:       v = tog;
                default: v = 1'($urandom_range(0, 1));
            endcase
            if (acc == abort_at) begin
                e = predict_fetch(1'b0, ce, a, 1'b1, {tag, "/abort"});
                cycle(1'b0, ce, a, 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                      1'b1, img[acc], e);
                return;
            end
            e = predict_fetch(1'b1, ce, a, 1'b1, {tag, "/load"});
            e.chk_ctrl = 1'b1;
            e.ready    = 1'b1;
            e.busy     = 1'b1;
            cycle(1'b1, ce, a, 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                  v, img[acc], e);
            if (v) begin
                acc++;
                if (acc % 4 == 0) begin
                    w = (acc / 4 - 1) % DEPTH;
                    ref_mem[w] = {img[acc-1], img[acc-2], img[acc-3], img[acc-4]};
                    known[w]   = 1'b1;
                end
            end
        end
        a  = rand_addr();
        ce = 1'($urandom_range(0, 1));
        e  = predict_fetch(1'b1, ce, a, 1'b1, {tag, "/done"});
        e.chk_ctrl = 1'b1;
        e.busy     = 1'b1;
        e.done     = 1'b1;
        cycle(1'b1, ce, a, 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
              1'b0, 8'h00, e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%08h required=%08h", name, act, req);
        end
    endtask

    // Monitor: one queued expectation is consumed per checked cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            if (exp_q.size() == 0) begin
                chk("queue_underflow", 32'd0, 32'd1);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e.chk_inst) chk({mon_e.tag, "/rom_inst"}, rom_inst, mon_e.inst);
                chk({mon_e.tag, "/misalign"}, 32'(misalign), 32'(mon_e.mis));
                if (mon_e.chk_ctrl) begin
                    chk({mon_e.tag, "/load_ready"}, 32'(load_ready), 32'(mon_e.ready));
                    chk({mon_e.tag, "/load_busy"},  32'(load_busy),  32'(mon_e.busy));
                    chk({mon_e.tag, "/load_done"},  32'(load_done),  32'(mon_e.done));
                end
                $display("txn %s inst=%08h mis=%0b rdy=%0b busy=%0b done=%0b",
                         mon_e.tag, rom_inst, misalign, load_ready, load_busy, load_done);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  img[$];
        exp_t        e;
        logic [31:0] a;
        int          nw;
        int          ab;
        for (int i = 0; i < DEPTH; i++) known[i] = 1'b0;
        rst = 1'b0; rom_ce = 1'b0; rom_addr = 32'h0; load_start = 1'b0;
        load_words = '0; load_valid = 1'b0; load_byte = 8'h00;
        @(posedge clk);
        #1;
        // Reset held low: output forced to zero even with rom_ce high.
        for (int i = 0; i < 2; i++) begin
            a = rand_addr();
            e = predict_fetch(1'b0, 1'b1, a, 1'b0, "in_reset");
            cycle(1'b0, 1'b1, a, 1'b0, 0, 1'b0, 8'h00, e);
        end
        idle_fetch(1'b1, 32'h0, "reset_state");

        img = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        run_load(2, img, 0, -1, "two_word");
        idle_fetch(1'b1, 32'h0, "fetch_0");
        idle_fetch(1'b1, 32'h4, "fetch_4");
        idle_fetch(1'b0, 32'h4, "ce_off");
        idle_fetch(1'b1, 32'h2, "fetch_2");

        img = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        run_load(1, img, 1, -1, "gapped");
        idle_fetch(1'b1, 32'h0, "deadbeef");

        img = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        run_load(2, img, 2, 6, "abort");
        idle_fetch(1'b1, 32'h0, "abort_w0");
        idle_fetch(1'b1, 32'h4, "abort_w1");

        img = {};
        for (int i = 0; i < 5; i++) img = {img, 8'(i), 8'h00, 8'h00, 8'h00};
        run_load(5, img, 0, -1, "wrap");
        idle_fetch(1'b1, 32'h0,  "wrap_0");
        idle_fetch(1'b1, 32'h10, "wrap_10");
        for (int i = 1; i < 4; i++) idle_fetch(1'b1, 32'(4 * i), "wrap_n");

        img = {};
        run_load(0, img, 0, -1, "zero");
        idle_fetch(1'b1, 32'h4, "after_zero");

        for (int k = 0; k < 10; k++) begin
            nw  = int'($urandom_range(0, 7));
            img = {};
            for (int i = 0; i < 4 * nw; i++) img.push_back(8'($urandom));
            ab = -1;
            if (nw > 0 && $urandom_range(0, 3) == 0) ab = int'($urandom_range(0, 4 * nw - 1));
            run_load(nw, img, int'($urandom_range(0, 2)), ab, $sformatf("rand%0d", k));
            for (int j = 0; j < 5; j++) begin
                idle_fetch(1'($urandom_range(0, 3) != 0), rand_addr(), $sformatf("rfetch%0d", k));
            end
        end

        chk_en = 1'b0;
        @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
